// File: rtl/uart_tx_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_ctrl
// Transmit-side byte buffer and sequencer for a UART transmitter. Host writes
// land in a 2**ADDR_W-entry synchronous FIFO; a two-state controller pops one
// byte at a time and hands it to the transmitter with a tx_start pulse, then
// waits for tx_done_tick before sending the next one.
//
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous, active-high reset
//   wr_en         in   host write strobe
//   wr_data       in   host write data [DBIT-1:0]
//   full          out  FIFO holds DEPTH entries
//   empty         out  FIFO holds 0 entries
//   count         out  FIFO occupancy 0..DEPTH [ADDR_W:0]
//   overflow_tick out  one-cycle pulse the cycle after a write was dropped
//   tx_start      out  one-cycle start pulse to the transmitter
//   tx_data       out  byte to the transmitter, held until the next pop
//   tx_done_tick  in   transmitter end-of-stop-bit pulse
//   busy          out  controller waiting on the transmitter or FIFO not empty
// -----------------------------------------------------------------------------
module uart_tx_fifo_ctrl #(
    parameter int DBIT   = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DBIT-1:0]   wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow_tick,
    output logic              tx_start,
    output logic [DBIT-1:0]   tx_data,
    input  logic              tx_done_tick,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [ADDR_W:0]   C_CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   C_CNT_ZERO = {(ADDR_W + 1){1'b0}};
    localparam logic [ADDR_W:0]   C_CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] C_PTR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] C_PTR_ONE  = {{(ADDR_W - 1){1'b0}}, 1'b1};
    localparam logic [DBIT-1:0]   C_DATA_ZERO = {DBIT{1'b0}};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    logic [DBIT-1:0]   r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;
    state_t            r_state;
    logic              r_tx_start;
    logic [DBIT-1:0]   r_tx_data;

    state_t            w_state_nxt;
    logic              w_tx_start_nxt;
    logic [DBIT-1:0]   w_tx_data_nxt;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    // Flags come from the registered count only, so a same-cycle pop never
    // makes room for a write.
    assign w_full  = (r_count == C_CNT_FULL);
    assign w_empty = (r_count == C_CNT_ZERO);
    assign w_push  = wr_en & ~w_full;
    // The only pop is the IDLE->WAIT hand-off to the transmitter.
    assign w_pop   = (r_state == ST_IDLE) & ~w_empty;

    // FIFO storage write port; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= C_PTR_ZERO;
            r_rd_ptr   <= C_PTR_ZERO;
            r_count    <= C_CNT_ZERO;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
            r_overflow <= wr_en & w_full;
        end
    end

    // Controller state and registered transmitter-side outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_tx_start <= 1'b0;
            r_tx_data  <= C_DATA_ZERO;
        end else begin
            r_state    <= w_state_nxt;
            r_tx_start <= w_tx_start_nxt;
            r_tx_data  <= w_tx_data_nxt;
        end
    end

    // Next-state and next-output decode; tx_done_tick only matters in WAIT.
    always_comb begin
        w_state_nxt    = r_state;
        w_tx_start_nxt = 1'b0;
        w_tx_data_nxt  = r_tx_data;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt    = ST_WAIT;
                    w_tx_start_nxt = 1'b1;
                    w_tx_data_nxt  = r_mem[r_rd_ptr];
                end else begin
                    w_state_nxt    = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (tx_done_tick) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign full          = w_full;
    assign empty         = w_empty;
    assign count         = r_count;
    assign overflow_tick = r_overflow;
    assign tx_start      = r_tx_start;
    assign tx_data       = r_tx_data;
    assign busy          = (r_state == ST_WAIT) | ~w_empty;

endmodule
